// File: rtl/core_sequencer.sv
// Boot and run controller for the riscv core: streams a length-prefixed program into
// instruction memory, holds the core in reset while loading, then follows halt/resume.
module core_sequencer #(
   parameter logic [31:0] BootVector = 32'h0000_0000,
   parameter int unsigned MaxWords   = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_data,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   output logic        core_reset,
   input  logic        halted,
   output logic        unhalt,
   input  logic        run_req,
   input  logic        reload_req,
   output logic [2:0]  state,
   output logic        error
);

   typedef enum logic [2:0] {
      LOAD_LEN  = 3'd0,
      LOAD_DATA = 3'd1,
      RUN       = 3'd2,
      HALTED    = 3'd3,
      RESUME    = 3'd4,
      ERROR     = 3'd5
   } state_t;

   localparam logic [31:0] MAX_LEN    = 32'(MaxWords);
   localparam logic [2:0]  REPULSE_AT = 3'd7;

   state_t      state_q, state_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [31:0] len_q, len_d;
   logic [15:0] idx_q, idx_d;
   logic [31:0] word_p0, word_d;
   logic        wr_vld_p1, wr_vld_d;
   logic [2:0]  res_cnt_q, res_cnt_d;
   logic        repulse_q, repulse_d;
   logic [31:0] addr_d, wdata_d;
   logic        ready_d, core_reset_d, unhalt_d, error_d;
   logic        accept;

   // Byte address of program word i; wraps mod 2^32 by construction.
   function automatic logic [31:0] word_addr(input logic [15:0] i);
      return BootVector + {14'd0, i, 2'b00};
   endfunction

   assign accept = cmd_valid & cmd_ready;
   assign state  = state_q;

   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      len_d      = len_q;
      idx_d      = idx_q;
      word_d     = word_p0;
      wr_vld_d   = 1'b0;
      res_cnt_d  = res_cnt_q;
      repulse_d  = repulse_q;
      addr_d     = mem_addr;
      wdata_d    = mem_wdata;
      unhalt_d   = 1'b0;
      error_d    = error;

      case (state_q)
         LOAD_LEN: begin
            if (accept) begin
               len_d      = {cmd_data, len_q[31:8]};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  if (len_d == 32'd0 || len_d > MAX_LEN) begin
                     state_d = ERROR;
                     error_d = 1'b1;
                  end else begin
                     state_d = LOAD_DATA;
                     idx_d   = '0;
                  end
               end
            end
         end
         LOAD_DATA: begin
            if (wr_vld_p1) begin
               idx_d = idx_q + 16'd1;
               if (({16'd0, idx_q} + 32'd1) == len_q) begin
                  state_d = RUN;
               end
            end else if (accept) begin
               word_d     = {cmd_data, word_p0[31:8]};
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  wr_vld_d = 1'b1;
                  addr_d   = word_addr(idx_q);
                  wdata_d  = word_d;
               end
            end
         end
         RUN: begin
            if (halted) begin
               state_d = HALTED;
            end
         end
         HALTED: begin
            if (reload_req) begin
               state_d    = LOAD_LEN;
               byte_cnt_d = '0;
               len_d      = '0;
               idx_d      = '0;
               word_d     = '0;
            end else if (run_req) begin
               state_d   = RESUME;
               unhalt_d  = 1'b1;
               res_cnt_d = '0;
               repulse_d = 1'b0;
            end
         end
         RESUME: begin
            if (!halted) begin
               state_d = RUN;
            end else if (!repulse_q) begin
               // Core missed the first pulse: nudge it exactly once more.
               if (res_cnt_q == REPULSE_AT) begin
                  unhalt_d  = 1'b1;
                  repulse_d = 1'b1;
               end else begin
                  res_cnt_d = res_cnt_q + 3'd1;
               end
            end
         end
         ERROR: begin
            error_d = 1'b1;
         end
         default: begin
            state_d = ERROR;
            error_d = 1'b1;
         end
      endcase

      core_reset_d = (state_d == LOAD_LEN) || (state_d == LOAD_DATA) || (state_d == ERROR);
      ready_d      = (state_d == LOAD_LEN) || ((state_d == LOAD_DATA) && !wr_vld_d);
   end

   // Stage boundary: every output and all control state are registered here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= LOAD_LEN;
         byte_cnt_q <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         word_p0    <= '0;
         wr_vld_p1  <= 1'b0;
         res_cnt_q  <= '0;
         repulse_q  <= 1'b0;
         cmd_ready  <= 1'b1;
         core_reset <= 1'b1;
         mem_wstrb  <= 4'h0;
         mem_addr   <= BootVector;
         mem_wdata  <= '0;
         unhalt     <= 1'b0;
         error      <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         len_q      <= len_d;
         idx_q      <= idx_d;
         word_p0    <= word_d;
         wr_vld_p1  <= wr_vld_d;
         res_cnt_q  <= res_cnt_d;
         repulse_q  <= repulse_d;
         cmd_ready  <= ready_d;
         core_reset <= core_reset_d;
         mem_wstrb  <= {4{wr_vld_d}};
         mem_addr   <= addr_d;
         mem_wdata  <= wdata_d;
         unhalt     <= unhalt_d;
         error      <= error_d;
      end
   end

endmodule
